// File: rtl/bsg_dff_skid_in.sv
// Two-entry ready/valid skid buffer feeding a bsg_dff stage.
// ready_o and data_o both come straight from flops, so no combinational path crosses the block.
module bsg_dff_skid_in #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_i,
  output logic [1:0]         count_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e             state_reg, state_next;
  logic [width_p-1:0] head_reg, head_next;
  logic [width_p-1:0] skid_reg, skid_next;
  logic               ready_reg, ready_next;
  logic               started_reg;
  logic               enq, deq;

  assign enq = v_i & ready_reg;
  assign deq = v_o & ready_i;

  always_comb begin
    state_next = state_reg;
    head_next  = head_reg;
    skid_next  = skid_reg;
    case (state_reg)
      EMPTY: begin
        if (enq) begin
          state_next = ONE;
          head_next  = data_i;
        end
      end
      ONE: begin
        if (enq && deq) begin
          head_next = data_i;
        end else if (enq) begin
          state_next = FULL;
          skid_next  = data_i;
        end else if (deq) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (deq) begin
          state_next = ONE;
          head_next  = skid_reg;
        end
      end
      default: state_next = EMPTY;
    endcase
    // started_reg keeps ready low for exactly one cycle after reset release
    ready_next = started_reg & (state_next != FULL);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg   <= EMPTY;
      head_reg    <= '0;
      skid_reg    <= '0;
      ready_reg   <= 1'b0;
      started_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      head_reg    <= head_next;
      skid_reg    <= skid_next;
      ready_reg   <= ready_next;
      started_reg <= 1'b1;
    end
  end

  assign ready_o = ready_reg;
  assign v_o     = (state_reg != EMPTY);
  assign data_o  = head_reg;
  assign count_o = state_reg;

  count_never_three: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    count_o != 2'd3);
  no_enq_when_full: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(state_reg == FULL && enq));

endmodule

// File: tb/tb_bsg_dff_skid_in.sv
// Bench for bsg_dff_skid_in: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_bsg_dff_skid_in;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b1;
  logic        v_i = 1'b0;
  logic [31:0] data_i = '0;
  logic        ready_o;
  logic        v_o;
  logic [31:0] data_o;
  logic        ready_i = 1'b0;
  logic [1:0]  count_o;

  int checks = 0;
  int errors = 0;

  bsg_dff_skid_in #(.width_p(32)) dut (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .v_i      (v_i),
    .data_i   (data_i),
    .ready_o  (ready_o),
    .v_o      (v_o),
    .data_o   (data_o),
    .ready_i  (ready_i),
    .count_o  (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of at most two words plus the ready timing rule.
  logic [31:0] q[$];
  bit          ready_m;
  bit          started_m;

  always @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      q.delete();
      ready_m   <= 1'b0;
      started_m <= 1'b0;
    end else begin
      if (q.size() != 0 && ready_i) void'(q.pop_front());
      if (v_i && ready_m) q.push_back(data_i);
      ready_m   <= started_m && (q.size() < 2);
      started_m <= 1'b1;
    end
  end

  // Compare process, sampling on the falling edge.
  bit          stall_prev;
  logic [31:0] data_prev;

  always @(negedge clk_i) begin
    if (!reset_n_i) begin
      chk("rst_ready", {31'd0, ready_o}, 32'd0);
      chk("rst_v", {31'd0, v_o}, 32'd0);
      chk("rst_count", {30'd0, count_o}, 32'd0);
      chk("rst_data", data_o, 32'd0);
      stall_prev = 1'b0;
    end else begin
      chk("m_ready", {31'd0, ready_o}, {31'd0, ready_m});
      chk("m_v", {31'd0, v_o}, {31'd0, q.size() != 0});
      chk("m_count", {30'd0, count_o}, 32'(q.size()));
      if (q.size() != 0) chk("m_data", data_o, q[0]);
      if (stall_prev) begin
        chk("stall_v", {31'd0, v_o}, 32'd1);
        chk("stall_data", data_o, data_prev);
      end
      stall_prev = v_o && !ready_i;
      data_prev  = data_o;
    end
  end

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // Reset then idle
    #1 reset_n_i = 1'b0;
    #2;
    chk("t1_ready", {31'd0, ready_o}, 32'd0);
    chk("t1_v", {31'd0, v_o}, 32'd0);
    chk("t1_count", {30'd0, count_o}, 32'd0);
    chk("t1_data", data_o, 32'd0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    #2 reset_n_i = 1'b1;
    step();
    chk("t1_ready_c1", {31'd0, ready_o}, 32'd0);
    step();
    chk("t1_ready_c2", {31'd0, ready_o}, 32'd1);

    // Single word
    v_i = 1'b1; data_i = 32'hDEADBEEF; ready_i = 1'b1;
    step();
    chk("t2_v", {31'd0, v_o}, 32'd1);
    chk("t2_data", data_o, 32'hDEADBEEF);
    v_i = 1'b0;
    step();
    chk("t2_v_after", {31'd0, v_o}, 32'd0);
    chk("t2_count_after", {30'd0, count_o}, 32'd0);

    // Streaming 0..7
    for (int i = 0; i < 8; i++) begin
      v_i = 1'b1; data_i = i;
      step();
      chk("t3_data", data_o, i);
      chk("t3_v", {31'd0, v_o}, 32'd1);
      chk("t3_ready", {31'd0, ready_o}, 32'd1);
    end
    v_i = 1'b0;
    step();
    chk("t3_v_end", {31'd0, v_o}, 32'd0);

    // Back-pressure into the skid entry
    ready_i = 1'b0; v_i = 1'b1; data_i = 32'd1;
    step();
    chk("t4_count1", {30'd0, count_o}, 32'd1);
    data_i = 32'd2;
    step();
    chk("t4_count2", {30'd0, count_o}, 32'd2);
    chk("t4_ready0", {31'd0, ready_o}, 32'd0);
    chk("t4_head1", data_o, 32'd1);
    data_i = 32'd3;
    step();
    chk("t4_hold_count", {30'd0, count_o}, 32'd2);
    chk("t4_hold_head", data_o, 32'd1);
    ready_i = 1'b1;
    step();
    chk("t4_head2", data_o, 32'd2);
    chk("t4_count_drain", {30'd0, count_o}, 32'd1);
    chk("t4_ready_back", {31'd0, ready_o}, 32'd1);
    step();
    chk("t4_head3", data_o, 32'd3);
    chk("t4_count3", {30'd0, count_o}, 32'd1);
    v_i = 1'b0;
    step();
    chk("t4_empty", {30'd0, count_o}, 32'd0);

    // Async reset while full
    ready_i = 1'b0; v_i = 1'b1; data_i = 32'hA;
    step();
    data_i = 32'hB;
    step();
    v_i = 1'b0;
    chk("t5_full", {30'd0, count_o}, 32'd2);
    @(negedge clk_i);
    #2 reset_n_i = 1'b0;
    #1;
    chk("t5_v", {31'd0, v_o}, 32'd0);
    chk("t5_ready", {31'd0, ready_o}, 32'd0);
    chk("t5_count", {30'd0, count_o}, 32'd0);
    chk("t5_data", data_o, 32'd0);
    step();
    step();
    @(negedge clk_i);
    #2 reset_n_i = 1'b1;
    step();
    chk("t5_ready_c1", {31'd0, ready_o}, 32'd0);
    step();
    chk("t5_ready_c2", {31'd0, ready_o}, 32'd1);
    v_i = 1'b1; data_i = 32'h55; ready_i = 1'b1;
    step();
    chk("t5_new_data", data_o, 32'h55);
    chk("t5_new_v", {31'd0, v_o}, 32'd1);
    v_i = 1'b0;
    step();

    // Random traffic against the model
    for (int i = 0; i < 10000; i++) begin
      v_i     = ($urandom_range(0, 3) != 0);
      data_i  = $urandom;
      ready_i = ($urandom_range(0, 3) != 0);
      step();
    end
    v_i = 1'b0; ready_i = 1'b1;
    repeat (4) step();
    chk("t6_drained", {30'd0, count_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
